// File: rtl/banco_nos_ativos_pkg.sv
// Shared definitions for the active-node bank: search FSM encoding,
// key width helper and one-hot slot-select checks.
package banco_nos_ativos_pkg;

   // Search FSM states, also exported on the debug port of the bank.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } estado_t;

   // Widest slot-select vector the helper functions accept.
   localparam int MAX_NA = 64;

   // Key = distancia + menor_vizinho needs one extra bit so it never overflows.
   function automatic int chave_width(input int distancia_width);
      return distancia_width + 1;
   endfunction

   // True when exactly one bit of the (zero-extended) select is set.
   function automatic logic um_quente(input logic [MAX_NA-1:0] v);
      return (v != '0) && ((v & (v - MAX_NA'(1))) == '0);
   endfunction

   // True when two or more bits of the (zero-extended) select are set.
   function automatic logic multiplos(input logic [MAX_NA-1:0] v);
      return (v & (v - MAX_NA'(1))) != '0;
   endfunction

endpackage

// File: rtl/banco_nos_ativos_if.sv
// Command/result bus between the active-node manager (master) and the
// active-node bank (slave).
// Handshake: a command is taken on every clk edge where atualizar_in or
// desativar_in is high with a one-hot habilitar_in; busca_in is a level
// sampled only while the search FSM is IDLE, and the result on menor_* is
// valid in the cycle busca_pronta_out is high and held until the next one.
interface banco_nos_ativos_if #(
   parameter int NUM_NA          = 8,
   parameter int ADDR_WIDTH      = 5,
   parameter int DISTANCIA_WIDTH = 5,
   parameter int CUSTO_WIDTH     = 4
);
   import banco_nos_ativos_pkg::*;

   logic [NUM_NA-1:0]            habilitar_in;
   logic                         atualizar_in;
   logic                         desativar_in;
   logic [ADDR_WIDTH-1:0]        endereco_in;
   logic [ADDR_WIDTH-1:0]        anterior_in;
   logic [CUSTO_WIDTH-1:0]       menor_vizinho_in;
   logic [DISTANCIA_WIDTH-1:0]   distancia_in;
   logic                         busca_in;

   logic [ADDR_WIDTH*NUM_NA-1:0] na_endereco_out;
   logic [NUM_NA-1:0]            na_ativo_out;
   logic                         busca_ocupada_out;
   logic                         busca_pronta_out;
   logic                         menor_valido_out;
   logic [ADDR_WIDTH-1:0]        menor_endereco_out;
   logic [ADDR_WIDTH-1:0]        menor_anterior_out;
   logic [DISTANCIA_WIDTH:0]     menor_chave_out;
   logic                         erro_out;
   estado_t                      estado;

   modport master (
      output habilitar_in, atualizar_in, desativar_in, endereco_in,
             anterior_in, menor_vizinho_in, distancia_in, busca_in,
      input  na_endereco_out, na_ativo_out, busca_ocupada_out,
             busca_pronta_out, menor_valido_out, menor_endereco_out,
             menor_anterior_out, menor_chave_out, erro_out, estado
   );

   modport slave (
      input  habilitar_in, atualizar_in, desativar_in, endereco_in,
             anterior_in, menor_vizinho_in, distancia_in, busca_in,
      output na_endereco_out, na_ativo_out, busca_ocupada_out,
             busca_pronta_out, menor_valido_out, menor_endereco_out,
             menor_anterior_out, menor_chave_out, erro_out, estado
   );

endinterface

// File: rtl/banco_nos_ativos_celula_no_ativo.sv
// One active-node slot: address, predecessor, smallest-neighbour cost and
// accumulated distance, with load / relax / free rules and a per-cycle
// protocol-error strobe for the bank's sticky error flag.
module celula_no_ativo #(
   parameter int ADDR_WIDTH      = 5,
   parameter int DISTANCIA_WIDTH = 5,
   parameter int CUSTO_WIDTH     = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       sel,
   input  logic                       atualizar,
   input  logic                       desativar,
   input  logic [ADDR_WIDTH-1:0]      endereco,
   input  logic [ADDR_WIDTH-1:0]      anterior,
   input  logic [CUSTO_WIDTH-1:0]     menor_vizinho,
   input  logic [DISTANCIA_WIDTH-1:0] distancia,
   output logic                       ativo,
   output logic [ADDR_WIDTH-1:0]      endereco_q,
   output logic [ADDR_WIDTH-1:0]      anterior_q,
   output logic [CUSTO_WIDTH-1:0]     menor_vizinho_q,
   output logic [DISTANCIA_WIDTH-1:0] distancia_q,
   output logic                       erro
);

   logic igual;
   logic carrega;

   assign igual = (endereco == endereco_q);

   // Decide whether this cycle's command loads the slot or is a protocol error.
   always_comb begin
      carrega = 1'b0;
      erro    = 1'b0;
      if (sel) begin
         if (desativar) begin
            // Free wins over a simultaneous update; the update is an error.
            erro = atualizar || !ativo || !igual;
         end else if (atualizar) begin
            if (!ativo) begin
               carrega = 1'b1;
            end else if (!igual) begin
               erro = 1'b1;
            end else begin
               // Relax only on a strictly shorter distance.
               carrega = (distancia < distancia_q);
            end
         end
      end
   end

   // Slot registers; a freed slot keeps its fields, only the flag drops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ativo           <= 1'b0;
         endereco_q      <= '0;
         anterior_q      <= '0;
         menor_vizinho_q <= '0;
         distancia_q     <= '0;
      end else if (carrega) begin
         ativo           <= 1'b1;
         endereco_q      <= endereco;
         anterior_q      <= anterior;
         menor_vizinho_q <= menor_vizinho;
         distancia_q     <= distancia;
      end else if (sel && desativar && ativo && igual) begin
         ativo <= 1'b0;
      end
   end

endmodule

// File: rtl/banco_nos_ativos.sv
// Active-node bank: NUM_NA slots written by the active-node manager, plus a
// sequential minimum search returning the active node with the smallest
// key = distancia + menor_vizinho (lowest index wins ties).
module banco_nos_ativos
   import banco_nos_ativos_pkg::*;
#(
   parameter int NUM_NA          = 8,
   parameter int ADDR_WIDTH      = 5,
   parameter int DISTANCIA_WIDTH = 5,
   parameter int CUSTO_WIDTH     = 4
) (
   input logic              clk,
   input logic              rst_n,
   banco_nos_ativos_if.slave bus
);

   localparam int CHAVE_W = chave_width(DISTANCIA_WIDTH);
   localparam int IDX_W   = $clog2(NUM_NA);
   localparam logic [IDX_W-1:0] IDX_ULTIMO = IDX_W'(NUM_NA - 1);

   logic                       comando;
   logic                       sel_valido;
   logic                       sel_multiplo;
   logic                       erro_q;
   logic [NUM_NA-1:0]          erro_cel;
   logic [NUM_NA-1:0]          ativo;
   logic [ADDR_WIDTH-1:0]      end_q  [NUM_NA];
   logic [ADDR_WIDTH-1:0]      ant_q  [NUM_NA];
   logic [CUSTO_WIDTH-1:0]     viz_q  [NUM_NA];
   logic [DISTANCIA_WIDTH-1:0] dist_q [NUM_NA];
   logic [ADDR_WIDTH*NUM_NA-1:0] pacote;

   estado_t               estado;
   logic [IDX_W-1:0]      idx;
   logic                  melhor_valido;
   logic [ADDR_WIDTH-1:0] melhor_end;
   logic [ADDR_WIDTH-1:0] melhor_ant;
   logic [CHAVE_W-1:0]    melhor_chave;

   logic [CHAVE_W-1:0]    chave_idx;
   logic                  melhora;
   logic                  nxt_valido;
   logic [ADDR_WIDTH-1:0] nxt_end;
   logic [ADDR_WIDTH-1:0] nxt_ant;
   logic [CHAVE_W-1:0]    nxt_chave;

   assign comando      = bus.atualizar_in | bus.desativar_in;
   assign sel_valido   = um_quente(MAX_NA'(bus.habilitar_in));
   assign sel_multiplo = multiplos(MAX_NA'(bus.habilitar_in));

   for (genvar i = 0; i < NUM_NA; i++) begin : g_celula
      celula_no_ativo #(
         .ADDR_WIDTH      (ADDR_WIDTH),
         .DISTANCIA_WIDTH (DISTANCIA_WIDTH),
         .CUSTO_WIDTH     (CUSTO_WIDTH)
      ) u_celula (
         .clk             (clk),
         .rst_n           (rst_n),
         .sel             (bus.habilitar_in[i] & sel_valido),
         .atualizar       (bus.atualizar_in),
         .desativar       (bus.desativar_in),
         .endereco        (bus.endereco_in),
         .anterior        (bus.anterior_in),
         .menor_vizinho   (bus.menor_vizinho_in),
         .distancia       (bus.distancia_in),
         .ativo           (ativo[i]),
         .endereco_q      (end_q[i]),
         .anterior_q      (ant_q[i]),
         .menor_vizinho_q (viz_q[i]),
         .distancia_q     (dist_q[i]),
         .erro            (erro_cel[i])
      );
   end

   // Sticky protocol error: multi-hot select with a command, or a slot-level fault.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         erro_q <= 1'b0;
      end else if ((comando && sel_multiplo) || (|erro_cel)) begin
         erro_q <= 1'b1;
      end
   end

   // Pack slot addresses for the manager's hit detection.
   always_comb begin
      pacote = '0;
      for (int i = 0; i < NUM_NA; i++) begin
         pacote[ADDR_WIDTH*i +: ADDR_WIDTH] = end_q[i];
      end
   end

   // Compare the slot under scan against the running best (strict less-than).
   always_comb begin
      chave_idx  = CHAVE_W'(dist_q[idx]) + CHAVE_W'(viz_q[idx]);
      melhora    = ativo[idx] && (!melhor_valido || (chave_idx < melhor_chave));
      nxt_valido = melhor_valido;
      nxt_end    = melhor_end;
      nxt_ant    = melhor_ant;
      nxt_chave  = melhor_chave;
      if (melhora) begin
         nxt_valido = 1'b1;
         nxt_end    = end_q[idx];
         nxt_ant    = ant_q[idx];
         nxt_chave  = chave_idx;
      end
   end

   // Search FSM: IDLE -> SCAN (one slot per cycle) -> DONE (result pulse) -> IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estado                 <= IDLE;
         idx                    <= '0;
         melhor_valido          <= 1'b0;
         melhor_end             <= '0;
         melhor_ant             <= '0;
         melhor_chave           <= '0;
         bus.busca_ocupada_out  <= 1'b0;
         bus.busca_pronta_out   <= 1'b0;
         bus.menor_valido_out   <= 1'b0;
         bus.menor_endereco_out <= '0;
         bus.menor_anterior_out <= '0;
         bus.menor_chave_out    <= '0;
      end else begin
         case (estado)
            IDLE: begin
               bus.busca_pronta_out <= 1'b0;
               if (bus.busca_in) begin
                  melhor_valido         <= 1'b0;
                  melhor_end            <= '0;
                  melhor_ant            <= '0;
                  melhor_chave          <= '0;
                  idx                   <= '0;
                  bus.busca_ocupada_out <= 1'b1;
                  estado                <= SCAN;
               end
            end
            SCAN: begin
               melhor_valido <= nxt_valido;
               melhor_end    <= nxt_end;
               melhor_ant    <= nxt_ant;
               melhor_chave  <= nxt_chave;
               if (idx == IDX_ULTIMO) begin
                  // Last slot folds straight into the published result.
                  bus.menor_valido_out   <= nxt_valido;
                  bus.menor_endereco_out <= nxt_end;
                  bus.menor_anterior_out <= nxt_ant;
                  bus.menor_chave_out    <= nxt_chave;
                  bus.busca_pronta_out   <= 1'b1;
                  estado                 <= DONE;
               end else begin
                  idx <= idx + IDX_W'(1);
               end
            end
            DONE: begin
               bus.busca_pronta_out  <= 1'b0;
               bus.busca_ocupada_out <= 1'b0;
               estado                <= IDLE;
            end
            default: begin
               estado <= IDLE;
            end
         endcase
      end
   end

   assign bus.na_endereco_out = pacote;
   assign bus.na_ativo_out    = ativo;
   assign bus.erro_out        = erro_q;
   assign bus.estado          = estado;

endmodule

// File: doc/banco_nos_ativos.md
Name: banco_nos_ativos

Overview:
Storage bank of NUM_NA active-node (NA) slots that receives the one-hot slot-select and command stream produced by the active-node manager, and feeds back `na_endereco_out` and `na_ativo_out` for hit detection.
Each slot holds the node address, predecessor, smallest-neighbour cost and accumulated distance.
A sequential search FSM scans all slots and returns the active node with the smallest key = distancia + menor_vizinho. This is the node the path-search controller expands next.

Parameters:
NUM_NA, 8, number of active-node slots (>=2)
ADDR_WIDTH, 5, node address width
DISTANCIA_WIDTH, 5, accumulated distance width
CUSTO_WIDTH, 4, neighbour cost width (<= DISTANCIA_WIDTH)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
habilitar_in  in  NUM_NA  one-hot slot select for current command
atualizar_in  in  1  write/relax command to selected slot
desativar_in  in  1  free command to selected slot
endereco_in  in  ADDR_WIDTH  node address
anterior_in  in  ADDR_WIDTH  predecessor address
menor_vizinho_in  in  CUSTO_WIDTH  smallest neighbour cost
distancia_in  in  DISTANCIA_WIDTH  accumulated distance
busca_in  in  1  start minimum search (level, sampled in IDLE)
na_endereco_out  out  ADDR_WIDTH*NUM_NA  packed slot addresses, slot i at [ADDR_WIDTH*i +: ADDR_WIDTH]
na_ativo_out  out  NUM_NA  slot active flags
busca_ocupada_out  out  1  FSM not IDLE
busca_pronta_out  out  1  one-cycle pulse: result valid
menor_valido_out  out  1  at least one active slot seen in last search
menor_endereco_out  out  ADDR_WIDTH  winner address
menor_anterior_out  out  ADDR_WIDTH  winner predecessor
menor_chave_out  out  DISTANCIA_WIDTH+1  winner key
erro_out  out  1  sticky protocol-error flag

Behaviour:
- Reset: all slot fields 0, na_ativo_out=0, FSM=IDLE, every output 0.
- Commands act on the clk edge where they are present. Slot registers update at that edge; the new values are visible on outputs in the next cycle.
- Command is valid only when habilitar_in is one-hot. Zero bits means the command is ignored. More than one bit means the command is ignored and erro_out is set.
- atualizar_in to an inactive slot: load endereco, anterior, menor_vizinho, distancia; set ativo=1.
- atualizar_in to an active slot with an equal address: relax. All fields are overwritten only if distancia_in < stored distancia; otherwise no change.
- atualizar_in to an active slot with a different address: no change; erro_out is set.
- desativar_in to an active slot with an equal address: clear ativo; fields are kept.
- desativar_in with an address mismatch, or to an inactive slot: no change; erro_out is set.
- atualizar_in and desativar_in together: desativar wins, atualizar is dropped, erro_out is set.
- erro_out is cleared only by reset.
- Search FSM: IDLE -> SCAN -> DONE -> IDLE.
  - IDLE: busca_in=1 clears the best register (valid=0) and sets idx=0, then goes to SCAN.
  - SCAN: one slot per cycle, idx = 0..NUM_NA-1. If slot idx is active, compute key = distancia + menor_vizinho, zero-extended to DISTANCIA_WIDTH+1 with no overflow. The slot replaces best if best is invalid or key < best key; strict compare, so ties keep the lowest index. After idx = NUM_NA-1, go to DONE.
  - DONE: busca_pronta_out=1 for one cycle; menor_* outputs latched; then IDLE.
  - menor_* outputs hold their value until the next DONE.
- Latency: busca_in high at edge t gives busca_pronta_out high in cycle t+NUM_NA+1.
- busca_in is ignored while not IDLE. If it is held high it retriggers from IDLE immediately after DONE.
- Commands are accepted during SCAN. The scan reads live slot registers, so a slot written before its index is visited is seen with its new value; otherwise its old value is used.
- No active slots: menor_valido_out=0 and menor_* outputs = 0 at DONE.
- idx counter width is $clog2(NUM_NA); it must not wrap before DONE for non-power-of-2 NUM_NA.

Decomposition:
- Shared package: FSM state encoding (IDLE, SCAN, DONE), key width constant DISTANCIA_WIDTH+1, and a one-hot check function reused by the manager.
- One sub-module, celula_no_ativo: a single slot's registers plus the relax/free/error logic. It is instantiated NUM_NA times in a generate loop.
- Search FSM and packing live in the top level.

Test Plan:
- Reset, then write slot0 with addr=3, dist=7, viz=2 -> next cycle na_ativo_out=8'b00000001 and na_endereco_out[4:0]=3.
- Relax: slot0 active addr=3 dist=7; atualizar addr=3 dist=4 -> dist=4. A second atualizar with dist=9 -> dist stays 4; erro_out=0.
- Slot0 key 9, slot2 key 5, slot5 key 5; busca_in pulse at t -> busca_pronta_out at t+9, menor_endereco_out = slot2 address, menor_chave_out=5.
- All slots inactive; busca_in -> pronta after NUM_NA+1 cycles, menor_valido_out=0, menor_* outputs=0.
- habilitar_in=8'b00000110 with atualizar_in -> no slot changes, erro_out=1 sticky. desativar_in with an address mismatch -> slot stays active.
- During SCAN at idx=1, desativar slot4 (the current minimum) -> result excludes slot4. rst_n low mid-SCAN -> FSM IDLE, na_ativo_out=0, no pronta pulse.
